// File: rtl/mult_seq_ctrl.sv
// Moore sequencer for a shift-add multiplier: load operands, then one test/add/shift
// step per multiplier bit, then a one-cycle done pulse.
module mult_seq_ctrl #(
    parameter int unsigned N     = 5,
    parameter int unsigned CNT_W = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             q_lsb,
    output logic             ld_ops,
    output logic             acc_sel,
    output logic             acc_en,
    output logic             shift_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] bit_idx
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
        StTest  = 3'd2,
        StAdd   = 3'd3,
        StShift = 3'd4,
        StDone  = 3'd5
    } state_e;

    localparam logic [CNT_W-1:0] CntInit = CNT_W'(N);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             ld_ops_d, acc_sel_d, acc_en_d, shift_en_d, busy_d, done_d;
    logic [CNT_W-1:0] bit_idx_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StLoad;
            StLoad: begin
                cnt_d   = CntInit;
                state_d = StTest;
            end
            StTest:  state_d = q_lsb ? StAdd : StShift;
            StAdd:   state_d = StShift;
            StShift: begin
                cnt_d   = cnt_q - CntOne;
                state_d = (cnt_q == CntOne) ? StDone : StTest;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies track state_q exactly.
    always_comb begin
        ld_ops_d   = 1'b0;
        acc_sel_d  = 1'b0;
        acc_en_d   = 1'b0;
        shift_en_d = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        bit_idx_d  = '0;
        unique case (state_d)
            StLoad: begin
                ld_ops_d = 1'b1;
                acc_en_d = 1'b1;
                busy_d   = 1'b1;
            end
            StTest: begin
                busy_d    = 1'b1;
                bit_idx_d = CntInit - cnt_d;
            end
            StAdd: begin
                acc_en_d  = 1'b1;
                acc_sel_d = 1'b1;
                busy_d    = 1'b1;
                bit_idx_d = CntInit - cnt_d;
            end
            StShift: begin
                shift_en_d = 1'b1;
                busy_d     = 1'b1;
                bit_idx_d  = CntInit - cnt_d;
            end
            StDone:  done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            ld_ops   <= 1'b0;
            acc_sel  <= 1'b0;
            acc_en   <= 1'b0;
            shift_en <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bit_idx  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ld_ops   <= ld_ops_d;
            acc_sel  <= acc_sel_d;
            acc_en   <= acc_en_d;
            shift_en <= shift_en_d;
            busy     <= busy_d;
            done     <= done_d;
            bit_idx  <= bit_idx_d;
        end
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl; a small shift-add datapath closes the loop on q_lsb
// so the product can be checked alongside the control pulses.
module tb_mult_seq_ctrl;

    localparam int unsigned N = 5;

    logic       clk = 1'b0;
    logic       rst_n, start, q_lsb;
    logic       ld_ops, acc_sel, acc_en, shift_en, busy, done;
    logic [2:0] bit_idx;

    logic [4:0]  a_in, b_in, mcand;
    logic [10:0] acc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mult_seq_ctrl #(.N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .q_lsb    (q_lsb),
        .ld_ops   (ld_ops),
        .acc_sel  (acc_sel),
        .acc_en   (acc_en),
        .shift_en (shift_en),
        .busy     (busy),
        .done     (done),
        .bit_idx  (bit_idx)
    );

    // acc = {carry, high half, multiplier}; the multiplier LSB drives q_lsb.
    always_ff @(posedge clk) begin
        if (ld_ops) begin
            mcand <= a_in;
            acc   <= {6'd0, b_in};
        end else if (acc_en && acc_sel) begin
            acc[10:5] <= {1'b0, acc[9:5]} + {1'b0, mcand};
        end else if (shift_en) begin
            acc <= acc >> 1;
        end
    end
    assign q_lsb = acc[0];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] out_vec();
        return {ld_ops, acc_sel, acc_en, shift_en, busy, done, bit_idx};
    endfunction

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic run_mult(input string tag, input logic [4:0] a, input logic [4:0] b,
                            input int exp_prod, input int exp_cycles, input int exp_adds,
                            input logic [4:0] exp_mask, input bit mid_start);
        int         cycles = 1;
        int         adds = 0;
        int         shifts = 0;
        int         bad_sel = 0;
        int         prod = -1;
        bit         got_done = 1'b0;
        logic [4:0] mask = '0;
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq({tag, "_load"}, 32'(ld_ops), 32'd1);
        for (int i = 0; i < 40 && !got_done; i++) begin
            @(negedge clk);
            cycles++;
            if (mid_start) start = (cycles == 6);
            if (acc_sel && !(acc_en && busy)) bad_sel++;
            if (acc_en && acc_sel) begin
                adds++;
                if (bit_idx < 5) mask[bit_idx] = 1'b1;
            end
            if (shift_en) shifts++;
            if (done) begin
                got_done = 1'b1;
                prod     = int'(acc[9:0]);
                if (busy) bad_sel++;
            end
        end
        start = 1'b0;
        check_eq({tag, "_done_seen"}, 32'(got_done), 32'd1);
        check_eq({tag, "_cycles"}, 32'(cycles), 32'(exp_cycles));
        check_eq({tag, "_adds"}, 32'(adds), 32'(exp_adds));
        check_eq({tag, "_shifts"}, 32'(shifts), 32'd5);
        check_eq({tag, "_add_idx"}, 32'(mask), 32'(exp_mask));
        check_eq({tag, "_product"}, 32'(prod), 32'(exp_prod));
        check_eq({tag, "_sel_busy"}, 32'(bad_sel), 32'd0);
        @(negedge clk);
        check_eq({tag, "_idle1"}, 32'(out_vec()), 32'd0);
        @(negedge clk);
        check_eq({tag, "_idle2"}, 32'(out_vec()), 32'd0);
    endtask

    initial begin
        int ld_at[3];
        int done_at[2];
        int n_ld, n_done, bad_prod, late_done;

        rst_n = 1'b0;
        start = 1'b1;
        a_in  = 5'd0;
        b_in  = 5'd0;

        // Reset held with start high
        repeat (3) @(negedge clk);
        check_eq("rst_outputs", 32'(out_vec()), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_release_load", 32'(ld_ops), 32'd1);
        check_eq("rst_release_busy", 32'(busy), 32'd1);
        start = 1'b0;
        wait_done("rst_run");

        run_mult("b_zero", 5'd13, 5'b00000, 0, 12, 0, 5'b00000, 1'b0);
        run_mult("b_10110", 5'd9, 5'b10110, 198, 15, 3, 5'b10110, 1'b0);
        run_mult("b_11111", 5'b11111, 5'b11111, 961, 17, 5, 5'b11111, 1'b1);

        // start held high: back-to-back runs of B=3
        @(negedge clk);
        a_in   = 5'd7;
        b_in   = 5'd3;
        start  = 1'b1;
        n_ld   = 0;
        n_done = 0;
        bad_prod = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (ld_ops && n_ld < 3) begin
                ld_at[n_ld] = c;
                n_ld++;
            end
            if (done && n_done < 2) begin
                done_at[n_done] = c;
                n_done++;
                if (acc[9:0] != 10'd21) bad_prod++;
            end
        end
        start = 1'b0;
        check_eq("hold_ld_count", 32'(n_ld), 32'd3);
        check_eq("hold_done_count", 32'(n_done), 32'd2);
        if (n_ld == 3 && n_done == 2) begin
            check_eq("hold_run1_len", 32'(done_at[0] - ld_at[0] + 1), 32'd14);
            check_eq("hold_run2_len", 32'(done_at[1] - ld_at[1] + 1), 32'd14);
            check_eq("hold_idle_gap", 32'(ld_at[1] - done_at[0]), 32'd2);
        end
        check_eq("hold_products", 32'(bad_prod), 32'd0);
        wait_done("hold_run3");
        check_eq("hold_run3_product", 32'(acc[9:0]), 32'd21);

        // Async reset during ADD
        @(negedge clk);
        a_in  = 5'd6;
        b_in  = 5'd11;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("arst_in_add", 32'(acc_sel), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_eq("arst_outputs_now", 32'(out_vec()), 32'd0);
        @(negedge clk);
        check_eq("arst_outputs_held", 32'(out_vec()), 32'd0);
        rst_n = 1'b1;
        late_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || busy) late_done++;
        end
        check_eq("arst_no_done", 32'(late_done), 32'd0);
        run_mult("arst_rerun", 5'd6, 5'd11, 66, 15, 3, 5'b01011, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
